// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator and pixel sink: counts h/v position, requests one pixel per
// active position and drives RGB444 plus syncs through a 3-stage registered pipeline.
module vga_timing_ctrl #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic        clk_v,
    input  logic        rst_v,
    input  logic        en_i,
    input  logic [11:0] data_i,
    output logic        data_req_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic [3:0]  red_o,
    output logic [3:0]  green_o,
    output logic [3:0]  blue_o,
    output logic        blank_o,
    output logic        frame_start_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    // Stage 0: raster position
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (!en_i) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
        end else begin
            h_cnt_d = h_cnt_q + HW'(1);
        end
    end

    always_ff @(posedge clk_v or posedge rst_v) begin
        if (rst_v) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Decode; gated by en_i so a disabled timer presents an idle raster downstream
    logic de, hs, vs, fs;
    always_comb begin
        de = en_i && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        hs = en_i && (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
        vs = en_i && (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
        fs = de && (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    // Stages 1 and 2: control delayed to meet the returning pixel word
    logic req_q, de1_q, hs1_q, vs1_q, fs1_q;
    logic de2_q, hs2_q, vs2_q, fs2_q;

    always_ff @(posedge clk_v or posedge rst_v) begin
        if (rst_v) begin
            req_q <= 1'b0;
            de1_q <= 1'b0;
            hs1_q <= 1'b0;
            vs1_q <= 1'b0;
            fs1_q <= 1'b0;
            de2_q <= 1'b0;
            hs2_q <= 1'b0;
            vs2_q <= 1'b0;
            fs2_q <= 1'b0;
        end else begin
            req_q <= de;
            de1_q <= de;
            hs1_q <= hs;
            vs1_q <= vs;
            fs1_q <= fs;
            de2_q <= de1_q;
            hs2_q <= hs1_q;
            vs2_q <= vs1_q;
            fs2_q <= fs1_q;
        end
    end

    // Stage 3: pin registers
    logic [11:0] rgb_q, rgb_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d, blank_q, blank_d, fstart_q, fstart_d;

    always_comb begin
        rgb_d    = de2_q ? data_i : 12'h000;
        hsync_d  = hs2_q ? SYNC_POL : ~SYNC_POL;
        vsync_d  = vs2_q ? SYNC_POL : ~SYNC_POL;
        blank_d  = ~de2_q;
        fstart_d = fs2_q;
    end

    always_ff @(posedge clk_v or posedge rst_v) begin
        if (rst_v) begin
            rgb_q    <= 12'h000;
            hsync_q  <= ~SYNC_POL;
            vsync_q  <= ~SYNC_POL;
            blank_q  <= 1'b1;
            fstart_q <= 1'b0;
        end else begin
            rgb_q    <= rgb_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            blank_q  <= blank_d;
            fstart_q <= fstart_d;
        end
    end

    assign data_req_o    = req_q;
    assign red_o         = rgb_q[11:8];
    assign green_o       = rgb_q[7:4];
    assign blue_o        = rgb_q[3:0];
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign blank_o       = blank_q;
    assign frame_start_o = fstart_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: default 640x480 active-low instance plus a tiny 16x8-total
// active-high instance so whole frames fit in a short run.
module tb_vga_timing_ctrl;

    logic        clk_v = 1'b0;
    logic        rst_v = 1'b1;
    logic        en_i  = 1'b1;
    logic [11:0] data_i;
    logic        data_req_o, hsync_o, vsync_o, blank_o, frame_start_o;
    logic [3:0]  red_o, green_o, blue_o;

    logic [11:0] s_data = 12'hABC;
    logic        s_req, s_hs, s_vs, s_blank, s_fs;
    logic [3:0]  s_r, s_g, s_b;

    int          req_idx;
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk_v = ~clk_v;

    vga_timing_ctrl u_dut (
        .clk_v        (clk_v),
        .rst_v        (rst_v),
        .en_i         (en_i),
        .data_i       (data_i),
        .data_req_o   (data_req_o),
        .hsync_o      (hsync_o),
        .vsync_o      (vsync_o),
        .red_o        (red_o),
        .green_o      (green_o),
        .blue_o       (blue_o),
        .blank_o      (blank_o),
        .frame_start_o(frame_start_o)
    );

    vga_timing_ctrl #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b1)
    ) u_small (
        .clk_v        (clk_v),
        .rst_v        (rst_v),
        .en_i         (en_i),
        .data_i       (s_data),
        .data_req_o   (s_req),
        .hsync_o      (s_hs),
        .vsync_o      (s_vs),
        .red_o        (s_r),
        .green_o      (s_g),
        .blue_o       (s_b),
        .blank_o      (s_blank),
        .frame_start_o(s_fs)
    );

    // Upstream line buffer: answers each request the next cycle with the request index
    always @(posedge clk_v or posedge rst_v) begin
        if (rst_v) begin
            data_i  <= 12'h000;
            req_idx <= 0;
        end else if (data_req_o) begin
            data_i  <= 12'(req_idx);
            req_idx <= req_idx + 1;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int rgb();
        return int'({red_o, green_o, blue_o});
    endfunction

    function automatic int s_rgb();
        return int'({s_r, s_g, s_b});
    endfunction

    initial begin
        int req_cnt = 0, req_first = -1, req_last = -1, blank0_first = -1;
        int hs_cnt = 0, hs_first = -1, pix_bad = 0, zero_bad = 0, fs_cnt = 0, fs_at = -1;
        int vs_low = 0;
        int s_req_cnt = 0, s_fs1 = -1, s_fs2 = -1, s_vs_cnt = 0, s_vs_first = -1;
        int s_hs_cnt = 0, s_hs_first = -1, s_rgb_bad = 0;

        // Reset with en_i high
        repeat (3) @(negedge clk_v);
        check("rst_hsync", int'(hsync_o), 1);
        check("rst_vsync", int'(vsync_o), 1);
        check("rst_blank", int'(blank_o), 1);
        check("rst_rgb", rgb(), 0);
        check("rst_req", int'(data_req_o), 0);
        check("rst_fs", int'(frame_start_o), 0);
        check("rst_s_hsync", int'(s_hs), 0);
        check("rst_s_vsync", int'(s_vs), 0);
        rst_v = 1'b0;
        @(negedge clk_v);

        // Sample c: data_req reflects counter c, pins reflect counter c-2
        for (int c = 0; c < 8300; c++) begin
            if (c < 800) begin
                if (data_req_o) begin
                    req_cnt++;
                    if (req_first < 0) req_first = c;
                    req_last = c;
                end
                if (!blank_o && blank0_first < 0) blank0_first = c;
                if (!hsync_o) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = c;
                end
                if (!blank_o && rgb() != int'(12'(c - 2))) pix_bad++;
                if (frame_start_o) begin
                    fs_cnt++;
                    fs_at = c;
                end
            end
            if (blank_o && rgb() != 0) zero_bad++;
            if (!vsync_o) vs_low++;
            if (c < 128 && s_req) s_req_cnt++;
            if (s_fs) begin
                if (s_fs1 < 0) s_fs1 = c;
                else if (s_fs2 < 0) s_fs2 = c;
            end
            if (c >= 2 && c < 130) begin
                if (s_vs) s_vs_cnt++;
                if (s_hs) s_hs_cnt++;
            end
            if (s_vs && s_vs_first < 0) s_vs_first = c;
            if (s_hs && s_hs_first < 0) s_hs_first = c;
            if (s_rgb() != (s_blank ? 0 : 12'hABC)) s_rgb_bad++;
            if (c == 8299) en_i = 1'b0;
            @(negedge clk_v);
        end

        check("line_req_count", req_cnt, 640);
        check("line_req_first", req_first, 0);
        check("line_req_last", req_last, 639);
        check("line_blank_first", blank0_first, 2);
        check("line_hs_offset", hs_first - blank0_first, 656);
        check("line_hs_width", hs_cnt, 96);
        check("line_pixel_bad", pix_bad, 0);
        check("fs_count_line0", fs_cnt, 1);
        check("fs_position", fs_at, 2);
        check("rgb_nonzero_in_blank", zero_bad, 0);
        check("vsync_early_low", vs_low, 0);
        check("s_frame_requests", s_req_cnt, 32);
        check("s_fs_first", s_fs1, 2);
        check("s_fs_period", s_fs2 - s_fs1, 128);
        check("s_vsync_width", s_vs_cnt, 32);
        check("s_vsync_first", s_vs_first, 82);
        check("s_hsync_count", s_hs_cnt, 24);
        check("s_hsync_first", s_hs_first, 12);
        check("s_rgb_bad", s_rgb_bad, 0);

        // en_i dropped at (h=300, v=10); now at sample 8300
        check("drop_req", int'(data_req_o), 0);
        check("drop_s_req", int'(s_req), 0);
        check("drop_rgb_8300", rgb(), 2602);
        @(negedge clk_v);
        check("drop_blank_8301", int'(blank_o), 0);
        check("drop_rgb_8301", rgb(), 2603);
        @(negedge clk_v);
        check("idle_blank", int'(blank_o), 1);
        check("idle_rgb", rgb(), 0);
        check("idle_hsync", int'(hsync_o), 1);
        check("idle_vsync", int'(vsync_o), 1);
        check("idle_s_blank", int'(s_blank), 1);
        check("idle_s_hsync", int'(s_hs), 0);
        check("idle_s_vsync", int'(s_vs), 0);
        repeat (5) @(negedge clk_v);
        check("idle_hold_blank", int'(blank_o), 1);
        check("idle_hold_fs", int'(frame_start_o), 0);

        // Re-enable: restart at (0,0) with a frame_start pulse
        en_i = 1'b1;
        @(negedge clk_v);
        check("reen_req", int'(data_req_o), 1);
        check("reen_fs_early", int'(frame_start_o), 0);
        @(negedge clk_v);
        check("reen_fs_early2", int'(frame_start_o), 0);
        @(negedge clk_v);
        check("reen_fs", int'(frame_start_o), 1);
        check("reen_blank", int'(blank_o), 0);
        check("reen_rgb", rgb(), 12'hA2C);
        @(negedge clk_v);
        check("reen_fs_pulse", int'(frame_start_o), 0);
        check("reen_rgb_next", rgb(), 12'hA2D);
        repeat (20) @(negedge clk_v);

        // Asynchronous reset mid-active
        check("pre_rst_blank", int'(blank_o), 0);
        #2 rst_v = 1'b1;
        #1;
        check("async_blank", int'(blank_o), 1);
        check("async_rgb", rgb(), 0);
        check("async_req", int'(data_req_o), 0);
        check("async_hsync", int'(hsync_o), 1);
        check("async_s_hsync", int'(s_hs), 0);
        check("async_s_blank", int'(s_blank), 1);
        @(negedge clk_v);
        rst_v = 1'b0;
        @(negedge clk_v);
        check("post_rst_req", int'(data_req_o), 1);
        repeat (2) @(negedge clk_v);
        check("post_rst_fs", int'(frame_start_o), 1);
        check("post_rst_s_fs", int'(s_fs), 1);
        @(negedge clk_v);
        check("post_rst_rgb1", rgb(), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
